// File: rtl/uart_echo_pkg.sv
// Shared definitions for the UART echo tester: FSM encoding, pattern LFSR
// polynomial and seeds, error-counter width and small helpers.
package uart_echo_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_WAIT_ECHO = 3'd2;
  localparam logic [2:0] ST_CHECK     = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam int ERR_W = 16;

  // x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3, shifted in at bit 0.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] INC_SEED  = 8'h00;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_echo_tester_pattern_gen.sv
// Test-pattern source: incrementing bytes, or an 8-bit Fibonacci LFSR when
// UART_ECHO_TESTER_LFSR_EN is defined.
module uart_pattern_gen
  import uart_echo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] data
);

`ifdef UART_ECHO_TESTER_LFSR_EN
  localparam logic [7:0] SEED = LFSR_SEED;
`else
  localparam logic [7:0] SEED = INC_SEED;
`endif

  logic [7:0] pat;
  logic [7:0] pat_next;

`ifdef UART_ECHO_TESTER_LFSR_EN
  assign pat_next = lfsr_next(pat);
`else
  assign pat_next = pat + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst || load) begin
      pat <= SEED;
    end else if (advance) begin
      pat <= pat_next;
    end
  end

  // The pattern itself is 8 bits; adapt to the byte-interface width.
  generate
    if (WIDTH > 8) begin : g_wide
      assign data = {{(WIDTH-8){1'b0}}, pat};
    end else if (WIDTH == 8) begin : g_exact
      assign data = pat;
    end else begin : g_narrow
      assign data = pat[WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/uart_echo_tester.sv
// UART loopback tester: sends NUM_BYTES pattern bytes, checks each echo,
// counts mismatches and timeouts. Pattern type set by UART_ECHO_TESTER_LFSR_EN.
module uart_echo_tester
  import uart_echo_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 sysclk,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [DATA_BITS-1:0] tx_data_out,
  output logic                 tx_valid_out,
  input  logic                 tx_ready_in,
  input  logic [DATA_BITS-1:0] rx_data_in,
  input  logic                 rx_data_rdy_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 pass_out,
  output logic [ERR_W-1:0]     err_count_out,
  output logic [2:0]           dbg_state
);

  localparam int             TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]    BYTE_LAST = 16'(NUM_BYTES - 1);

  logic [2:0]           state;
  logic [15:0]          byte_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [DATA_BITS-1:0] echo;
  logic [DATA_BITS-1:0] pattern;
  logic                 timed_out;
  logic                 load;
  logic                 advance;

  assign load    = start_in && ((state == ST_IDLE) || (state == ST_DONE));
  assign advance = (state == ST_CHECK);

  uart_pattern_gen #(.WIDTH(DATA_BITS)) u_pattern (
    .clk     (sysclk),
    .rst     (rst_in),
    .load    (load),
    .advance (advance),
    .data    (pattern)
  );

  // TX handshake: a byte moves on a rising edge where tx_valid_out and
  // tx_ready_in are both high; while valid is high and ready low the byte
  // is held unchanged and valid never drops before the transfer.
  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      to_cnt        <= '0;
      echo          <= '0;
      timed_out     <= 1'b0;
      err_count_out <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_in) begin
            state         <= ST_SEND;
            byte_cnt      <= '0;
            to_cnt        <= '0;
            timed_out     <= 1'b0;
            err_count_out <= '0;
          end
        end
        ST_SEND: begin
          if (tx_ready_in) begin
            state     <= ST_WAIT_ECHO;
            to_cnt    <= '0;
            timed_out <= 1'b0;
          end
        end
        ST_WAIT_ECHO: begin
          if (rx_data_rdy_in) begin
            echo  <= rx_data_in;
            state <= ST_CHECK;
          end else if (to_cnt == TO_LAST) begin
            // Timeout is charged here; CHECK then skips the compare.
            timed_out     <= 1'b1;
            err_count_out <= sat_inc(err_count_out);
            state         <= ST_CHECK;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!timed_out && (echo != pattern)) begin
            err_count_out <= sat_inc(err_count_out);
          end
          byte_cnt <= byte_cnt + 16'd1;
          state    <= (byte_cnt == BYTE_LAST) ? ST_DONE : ST_SEND;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_valid_out = (state == ST_SEND);
  assign tx_data_out  = tx_valid_out ? pattern : '0;
  assign busy_out     = (state == ST_SEND) || (state == ST_WAIT_ECHO) || (state == ST_CHECK);
  assign done_out     = (state == ST_DONE);
  assign pass_out     = done_out && (err_count_out == '0);
  assign dbg_state    = state;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: a loopback UART model with per-byte random echo
// delay, corruption, drop, backpressure and abort, checked against a pattern model.
module tb_uart_echo_tester;
  import uart_echo_pkg::*;

  localparam int NB     = 16;
  localparam int BUDGET = 20000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel, start, tx_ready, rx_rdy;
  logic [7:0] rx_data;
  logic       rst_a, rst_b;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic [7:0]  a_tx_data, b_tx_data;
  logic        a_tx_valid, b_tx_valid, a_busy, b_busy, a_done, b_done, a_pass, b_pass;
  logic [15:0] a_err, b_err;
  logic [2:0]  a_dbg, b_dbg;

  uart_echo_tester #(.DATA_BITS(8), .NUM_BYTES(NB)) dut_a (
    .sysclk(clk), .rst_in(rst_a), .start_in(start),
    .tx_data_out(a_tx_data), .tx_valid_out(a_tx_valid), .tx_ready_in(tx_ready),
    .rx_data_in(rx_data), .rx_data_rdy_in(rx_rdy),
    .busy_out(a_busy), .done_out(a_done), .pass_out(a_pass),
    .err_count_out(a_err), .dbg_state(a_dbg)
  );

  uart_echo_tester #(.DATA_BITS(8), .NUM_BYTES(NB), .TIMEOUT_CYCLES(50)) dut_b (
    .sysclk(clk), .rst_in(rst_b), .start_in(start),
    .tx_data_out(b_tx_data), .tx_valid_out(b_tx_valid), .tx_ready_in(tx_ready),
    .rx_data_in(rx_data), .rx_data_rdy_in(rx_rdy),
    .busy_out(b_busy), .done_out(b_done), .pass_out(b_pass),
    .err_count_out(b_err), .dbg_state(b_dbg)
  );

  logic [7:0]  tx_data;
  logic        tx_valid, busy, done, pass;
  logic [15:0] err_count;
  logic [2:0]  dbg;
  assign tx_data   = sel ? b_tx_data  : a_tx_data;
  assign tx_valid  = sel ? b_tx_valid : a_tx_valid;
  assign busy      = sel ? b_busy     : a_busy;
  assign done      = sel ? b_done     : a_done;
  assign pass      = sel ? b_pass     : a_pass;
  assign err_count = sel ? b_err      : a_err;
  assign dbg       = sel ? b_dbg      : a_dbg;

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  sent_q[$];
  int          hs_count, wait_cycles, unstable;
  bit          run_timeout, first_valid;
  logic        first_done;
  logic [15:0] first_err;

  function automatic logic [7:0] model_byte(input int i);
    logic [7:0] b;
`ifdef UART_ECHO_TESTER_LFSR_EN
    b = 8'h01;
    for (int k = 0; k < i; k++) b = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
`else
    b = 8'(i % 256);
`endif
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loopback UART model driving one run cycle by cycle.
  task automatic run_test(input int dly_min, input int dly_max, input int bad_idx,
                          input int drop_idx, input int bp, input int abort_idx,
                          input int poke_idx, input bit spurious);
    int bp_left, echo_left, hs_idx, cyc;
    bit echo_pend, hold_pending, aborted;
    logic [7:0] echo_byte, held_data;
    sent_q.delete();
    hs_count = 0; wait_cycles = 0; unstable = 0; run_timeout = 0;
    echo_pend = 0; hold_pending = 0; aborted = 0; hs_idx = -1; cyc = 0;
    bp_left = bp; echo_left = 0; echo_byte = 8'h00; held_data = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    first_valid = tx_valid; first_done = done; first_err = err_count;
    while (!done && !aborted) begin
      if (cyc >= BUDGET) begin run_timeout = 1; break; end
      rx_rdy = 1'b0; start = 1'b0; tx_ready = 1'b0;
      if (hold_pending && (!tx_valid || tx_data !== held_data)) unstable++;
      hold_pending = 0;
      if (dbg == ST_WAIT_ECHO && hs_idx == drop_idx) wait_cycles++;
      if (dbg == ST_WAIT_ECHO && hs_idx == poke_idx) start = 1'b1;
      if (echo_pend) begin
        if (echo_left == 0) begin rx_rdy = 1'b1; rx_data = echo_byte; echo_pend = 0; end
        else echo_left--;
      end
      if (tx_valid) begin
        if (hs_idx + 1 == abort_idx) begin
          rst = 1'b1; aborted = 1;
        end else if (bp_left > 0) begin
          bp_left--; hold_pending = 1; held_data = tx_data;
          if (spurious) begin rx_rdy = 1'b1; rx_data = 8'($urandom_range(0, 255)); end
        end else begin
          tx_ready = 1'b1; hs_idx++; hs_count++; sent_q.push_back(tx_data);
          echo_byte = tx_data ^ ((hs_idx == bad_idx) ? 8'h01 : 8'h00);
          bp_left = bp;
          if (hs_idx != drop_idx) begin
            echo_pend = 1; echo_left = int'($urandom_range(dly_min, dly_max));
          end
        end
      end
      step();
      cyc++;
    end
    rx_rdy = 1'b0; tx_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; start = 1'b0; tx_ready = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    repeat (3) step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    rst = 1'b0;
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ideal();
    run_test(100, 100, -1, -1, 0, -1, -1, 0);
    checks++; if (run_timeout) begin errors++; $display("FAIL ideal_budget: run did not finish within %0d cycles", BUDGET); end
    checks++; if (first_valid !== 1'b1) begin errors++; $display("FAIL ideal_first_valid: got %b want 1", first_valid); end
    checks++; if (hs_count != NB) begin errors++; $display("FAIL ideal_handshakes: got %0d want %0d", hs_count, NB); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ideal_byte%0d: got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_q[i]);
      end
    end
`ifdef UART_ECHO_TESTER_LFSR_EN
    begin
      logic [7:0] lfsr_first[4];
      lfsr_first = '{8'h01, 8'h02, 8'h04, 8'h08};
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (i >= sent_q.size() || sent_q[i] !== lfsr_first[i]) begin
          errors++; $display("FAIL lfsr_byte%0d: got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, lfsr_first[i]);
        end
      end
    end
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ideal_done: got %b want 1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %b want 1", pass); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL ideal_err: got %0d want 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ideal_busy: got %b want 0", busy); end
    repeat (5) step();
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL ideal_done_held: got done=%b pass=%b want 1/1", done, pass); end
  endtask

  task automatic test_corrupt();
    run_test(1, 200, 5, -1, 0, -1, -1, 0);
    checks++; if (hs_count != NB) begin errors++; $display("FAIL corrupt_handshakes: got %0d want %0d", hs_count, NB); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL corrupt_err: got %0d want 1", err_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b want 0", pass); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL corrupt_done: got %b want 1", done); end
  endtask

  task automatic test_backpressure();
    run_test(1, 30, -1, -1, 10, -1, 3, 1);
    checks++; if (first_done !== 1'b0 || first_err !== 16'h0) begin errors++; $display("FAIL restart_clear: got done=%b err=%0d want 0/0", first_done, first_err); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
    checks++; if (hs_count != NB) begin errors++; $display("FAIL bp_handshakes: got %0d want %0d", hs_count, NB); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_byte%0d: got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin errors++; $display("FAIL bp_pass: got pass=%b err=%0d want 1/0", pass, err_count); end
  endtask

  task automatic test_reset_mid_run();
    bit moved;
    run_test(1, 30, -1, -1, 0, 7, -1, 0);
    checks++; if (hs_count != 7) begin errors++; $display("FAIL abort_handshakes: got %0d want 7", hs_count); end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'h0) begin
      errors++; $display("FAIL abort_outputs: got valid=%b data=%h busy=%b done=%b pass=%b err=%0d want all 0",
                        tx_valid, tx_data, busy, done, pass, err_count);
    end
    rst = 1'b0;
    moved = 0;
    repeat (5) begin step(); if (tx_valid !== 1'b0 || busy !== 1'b0) moved = 1; end
    checks++; if (moved) begin errors++; $display("FAIL abort_quiet: got activity after reset want none"); end
    run_test(1, 30, -1, -1, 0, -1, -1, 0);
    checks++; if (sent_q.size() == 0 || sent_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_restart_first: got %h want %h", (sent_q.size() > 0) ? sent_q[0] : 8'hxx, exp_q[0]); end
    checks++; if (hs_count != NB || pass !== 1'b1) begin errors++; $display("FAIL abort_restart_run: got hs=%0d pass=%b want %0d/1", hs_count, pass, NB); end
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    step();
    run_test(1, 40, -1, 3, 0, -1, -1, 0);
    checks++; if (wait_cycles != 50) begin errors++; $display("FAIL timeout_wait: got %0d cycles want 50", wait_cycles); end
    checks++; if (hs_count != NB) begin errors++; $display("FAIL timeout_handshakes: got %0d want %0d", hs_count, NB); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL timeout_err: got %0d want 1", err_count); end
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL timeout_done: got done=%b pass=%b want 1/0", done, pass); end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) exp_q.push_back(model_byte(i));
    test_reset();
    test_ideal();
    test_corrupt();
    test_backpressure();
    test_reset_mid_run();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_tester.md
UART_ECHO_TESTER -- requirements
Module: uart_echo_tester

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: byte width on the TX/RX byte interfaces.
REQ-002 SHALL have parameter NUM_BYTES, default 16: bytes sent per test run (1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 20000: sysclk cycles allowed per echo (about 2 UART frames at 100 MHz / 115200 baud).
REQ-004 SHALL have port sysclk, input, 1 bit: single clock; all logic sits on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start_in, input, 1 bit: starts a run when high in IDLE or DONE.
REQ-007 SHALL have port tx_data_out, output, DATA_BITS: byte to the UART transmitter.
REQ-008 SHALL have port tx_valid_out, output, 1 bit: tx_data_out is valid.
REQ-009 SHALL have port tx_ready_in, input, 1 bit: transmitter accepts the byte; transfer happens when valid and ready are both high.
REQ-010 SHALL have port rx_data_in, input, DATA_BITS: byte from the UART receiver.
REQ-011 SHALL have port rx_data_rdy_in, input, 1 bit: 1-cycle pulse, rx_data_in valid.
REQ-012 SHALL have port busy_out, output, 1 bit: a run is in progress.
REQ-013 SHALL have port done_out, output, 1 bit: the run is finished; held until the next start or reset.
REQ-014 SHALL have port pass_out, output, 1 bit: valid while done_out is high; 1 when err_count_out==0.
REQ-015 SHALL have port err_count_out, output, 16 bits: count of mismatches plus timeouts, saturating.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, WAIT_ECHO, CHECK, DONE.
REQ-017 SHALL go IDLE/DONE->SEND on start_in; in that cycle it loads the pattern seed, clears err_count_out and the byte counter, and clears done_out.
REQ-018 SHALL, in SEND, drive tx_valid_out=1 with the current pattern byte and hold the byte stable until the handshake; on the handshake it goes to WAIT_ECHO.
REQ-019 SHALL, in WAIT_ECHO, register rx_data_in on rx_data_rdy_in and go to CHECK.
REQ-020 SHALL, in CHECK (one cycle), compare the registered echo with the sent byte and add 1 to err_count_out on mismatch.
REQ-021 SHALL, if TIMEOUT_CYCLES elapse in WAIT_ECHO with no echo, add 1 to err_count_out and go to CHECK with the compare suppressed.
REQ-022 SHALL, after CHECK, advance the pattern and the byte counter; when byte counter==NUM_BYTES it goes to DONE, otherwise to SEND.
REQ-023 SHALL set first tx_valid_out one cycle after start_in is sampled.
REQ-024 SHALL ignore rx_data_rdy_in in IDLE, SEND, CHECK and DONE.
REQ-025 SHALL ignore start_in while busy_out is high.
REQ-026 SHALL saturate err_count_out at 16'hFFFF with no wrap.
REQ-027 SHALL drive busy_out=1 in SEND, WAIT_ECHO and CHECK, and done_out=1 only in DONE.

Reset
REQ-028 SHALL, on rst_in, go to IDLE and set tx_valid_out=0, tx_data_out=0, busy_out=0, done_out=0, pass_out=0, err_count_out=0, and clear the timeout and byte counters.
REQ-029 SHALL, on rst_in mid-run, abort the run with no further transfer; the next start_in begins a fresh run.

Configuration
REQ-030 SHALL, with UART_ECHO_TESTER_LFSR_EN defined, generate the pattern from an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed 8'h01.
REQ-031 SHALL, without UART_ECHO_TESTER_LFSR_EN, generate an incrementing pattern from 8'h00 that wraps 8'hFF->8'h00.

Structure
REQ-032 SHALL place the FSM state encoding, the LFSR polynomial, the seed and the error-counter width in the shared package uart_echo_pkg.
REQ-033 SHALL implement the pattern source as sub-module uart_pattern_gen (ports: load, advance, data).

Verification
REQ-034 SHALL cover ideal echo: loopback model with tx_ready_in=1 and echo after 100 cycles, NUM_BYTES=16, no LFSR -> bytes 00..0F sent, done_out=1, pass_out=1, err_count_out=0.
REQ-035 SHALL cover corrupted echo: model XORs byte 5 with 8'h01 -> err_count_out=1, pass_out=0.
REQ-036 SHALL cover timeout: no echo for byte 3, TIMEOUT_CYCLES=50 -> WAIT_ECHO exits after 50 cycles, err_count_out=1, run still completes all 16 bytes.
REQ-037 SHALL cover backpressure: tx_ready_in low for 10 cycles per byte -> tx_data_out stable while tx_valid_out is high, exactly 16 handshakes.
REQ-038 SHALL cover reset mid-run: rst_in at byte 7 -> all outputs 0 next cycle; a new start_in resends from 8'h00 (or 8'h01 with LFSR_EN).
REQ-039 SHALL cover LFSR: with UART_ECHO_TESTER_LFSR_EN, first 4 bytes 01, 02, 04, 08 -> matches the reference model sequence and pass_out=1.
